dac_mixer_spi: RTL and testbench
================================

DAC_MIXER_SPI -- requirements
Module: dac_mixer_spi

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning the number of 11-bit channel inputs mixed (2 or 4).
REQ-002 SHALL have parameter SCLK_DIV, default 2, meaning the SCLK half-period in clk cycles (>=1).
REQ-003 SHALL have parameter SAMPLE_DIV, default 250, meaning clk cycles per DAC sample (48 kHz at 12 MHz).
REQ-004 SHALL have port clk, input, 1 bit: the single system clock, 12 MHz.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port ch_in, input, NUM_CH*11 bits: packed channel samples, channel k at [11k+10:11k].
REQ-007 SHALL have port ch_mute, input, NUM_CH bits: 1 = channel k contributes 0 to the mix.
REQ-008 SHALL have port enable, input, 1 bit: 1 = start frames on sample ticks.
REQ-009 SHALL have ports sclk, mosi, cs_n, all outputs, 1 bit each: SPI mode 0 to a 12-bit DAC.
REQ-010 SHALL have port ldac_n, output, 1 bit: DAC latch strobe.
REQ-011 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-013 Sample timer SHALL count 0..SAMPLE_DIV-1 and wrap; a tick SHALL occur on the cycle the count equals SAMPLE_DIV-1.
REQ-014 Mix = unsigned sum of unmuted channels, width 11+$clog2(NUM_CH); data word = top 12 bits of the sum, so no overflow or clipping is possible.
REQ-015 On a tick with state IDLE and enable=1, the block SHALL capture the 16-bit word {4'b0011, data} into the shift register and enter SHIFT.
REQ-016 Any tick not in IDLE, or with enable=0, SHALL be ignored.
REQ-017 States SHALL be IDLE -> SHIFT -> END -> (LDAC when the macro is defined) -> IDLE.
REQ-018 cs_n SHALL go low the cycle after the tick; mosi SHALL carry bit 15 first (MSB first).
REQ-019 Each bit SHALL occupy 2*SCLK_DIV cycles: sclk low for SCLK_DIV cycles, then high for SCLK_DIV cycles; mosi SHALL change only while sclk is low.
REQ-020 After the 16th high phase, state SHALL be END for 1 cycle: sclk=0, cs_n=1, frame_done=1.
REQ-021 busy SHALL equal (state != IDLE).
REQ-022 Frame length SHALL be 32*SCLK_DIV+1 cycles, or +2 with LDAC.
REQ-023 An elaboration-time assertion SHALL require SAMPLE_DIV >= 32*SCLK_DIV+4.
REQ-024 enable deasserted mid-frame SHALL let the current frame complete; no new frame SHALL start.
REQ-025 ch_in and ch_mute changes mid-frame SHALL NOT affect the frame in flight.

Reset
REQ-026 While rst_n=0, the block SHALL immediately force: state IDLE, timer 0, shift register 0, cs_n=1, sclk=0, mosi=0, busy=0, frame_done=0, and ldac_n=1 (macro) or 0 (no macro).
REQ-027 Reset mid-frame SHALL abort the frame with no frame_done; the first tick after release SHALL occur SAMPLE_DIV cycles later.

Configuration
REQ-028 With macro DAC_LDAC_EN defined:
- the LDAC state SHALL drive ldac_n=0 for exactly 1 cycle, the cycle after END;
- ldac_n SHALL otherwise be 1.
REQ-029 Without DAC_LDAC_EN, ldac_n SHALL be constant 0 (the DAC updates on cs_n rising) and there SHALL be no LDAC state.

Structure
REQ-030 Package synth_pkg SHALL hold: CH_BITS=11, DAC_BITS=12, DAC_CFG=4'b0011, FRAME_BITS=16, and the dac_state_t enum.
REQ-031 Mixing SHALL be a combinational sub-module channel_mixer (ch_in, ch_mute -> 12-bit data).
REQ-032 The FSM, timer and shifter SHALL live in dac_mixer_spi.

Verification (NUM_CH=2, SCLK_DIV=2, SAMPLE_DIV=250)
REQ-033 ch_in ch0=0x400, ch1=0x3FF, no mute -> word 0x37FF shifted MSB first; one cycle of frame_done.
REQ-034 ch0=0x7FF, ch1=0x7FF -> word 0x3FFE; with ch_mute=2'b10 -> word 0x37FF.
REQ-035 Timing:
- cs_n falls 1 cycle after the tick;
- exactly 16 sclk rising edges with period 4 clk;
- busy high for 65 cycles (66 with DAC_LDAC_EN);
- frames start every 250 cycles.
REQ-036 enable=0 -> cs_n stays 1 across 3 ticks; enable dropped at bit 8 -> that frame completes and the next tick is ignored.
REQ-037 rst_n pulsed low at bit 7 -> cs_n=1 and sclk=0 without waiting for a clk edge, no frame_done; the next frame starts 250 cycles after release.
REQ-038 With DAC_LDAC_EN, ldac_n is low for exactly 1 cycle, 1 cycle after cs_n rises; without it, ldac_n is 0 throughout.

Source files
------------

// File: rtl/synth_pkg.sv
// synth_pkg -- shared constants and FSM state type for the DAC mixer / SPI block.
//   CH_BITS    : width of one mixer channel input
//   DAC_BITS   : width of the DAC data field
//   DAC_CFG    : 4-bit command/config nibble sent ahead of the data
//   FRAME_BITS : SPI frame length
// Optional feature macro: DAC_LDAC_EN (adds the ST_LDAC state).
package synth_pkg;

  localparam int         CH_BITS    = 11;
  localparam int         DAC_BITS   = 12;
  localparam int         FRAME_BITS = 16;
  localparam logic [3:0] DAC_CFG    = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_END   = 2'd2
`ifdef DAC_LDAC_EN
    , ST_LDAC = 2'd3
`endif
  } dac_state_t;

endpackage

// File: rtl/dac_mixer_spi_if.sv
// dac_mixer_spi_if -- serial link to a 12-bit SPI DAC (mode 0).
//   sclk   : serial clock, idles low
//   mosi   : serial data, MSB first
//   cs_n   : chip select, active low
//   ldac_n : DAC latch strobe, active low
// Modports: master (the controller drives), slave (the DAC side observes).
interface dac_mixer_spi_if;

  logic sclk;
  logic mosi;
  logic cs_n;
  logic ldac_n;

  modport master (output sclk, output mosi, output cs_n, output ldac_n);
  modport slave  (input  sclk, input  mosi, input  cs_n, input  ldac_n);

endinterface

// File: rtl/dac_mixer_spi_mixer.sv
// channel_mixer -- combinational unsigned mix of NUM_CH 11-bit channels.
//   ch_in   : packed samples, channel k at [11k+10:11k]
//   ch_mute : 1 = channel k contributes 0
//   data    : top 12 bits of the full-width sum
// The sum is sized 11+clog2(NUM_CH), so it can never overflow; taking its
// top 12 bits scales the result into the DAC range without clipping.
module channel_mixer
  import synth_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH*CH_BITS-1:0] ch_in,
  input  logic [NUM_CH-1:0]         ch_mute,
  output logic [DAC_BITS-1:0]       data
);

  localparam int SUM_W = CH_BITS + $clog2(NUM_CH);

  logic [SUM_W-1:0] sum;

  always_comb begin
    sum = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!ch_mute[k]) begin
        sum = sum + SUM_W'(ch_in[k*CH_BITS +: CH_BITS]);
      end
    end
  end

  assign data = sum[SUM_W-1 -: DAC_BITS];

endmodule

// File: rtl/dac_mixer_spi.sv
// dac_mixer_spi -- mixes NUM_CH channels and ships each sample to a 12-bit
// SPI DAC once per SAMPLE_DIV clocks.
//   clk, rst_n : system clock, async active-low reset
//   ch_in      : packed 11-bit channel samples
//   ch_mute    : per-channel mute
//   enable     : 1 = start a frame on each sample tick
//   spi        : sclk / mosi / cs_n / ldac_n (master modport)
//   busy       : frame in progress
//   frame_done : one-cycle pulse in the END state
// Optional feature macro: DAC_LDAC_EN -- adds a one-cycle ldac_n strobe
// after END; without it ldac_n is tied low and the DAC updates on cs_n rise.
//
// state    | meaning
// ST_IDLE  | waiting for a sample tick with enable=1
// ST_SHIFT | 16 bits out, each SCLK_DIV low + SCLK_DIV high cycles
// ST_END   | cs_n released, frame_done pulsed
// ST_LDAC  | ldac_n low for one cycle (DAC_LDAC_EN only)
module dac_mixer_spi
  import synth_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int SCLK_DIV   = 2,
  parameter int SAMPLE_DIV = 250
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH*CH_BITS-1:0] ch_in,
  input  logic [NUM_CH-1:0]         ch_mute,
  input  logic                      enable,
  dac_mixer_spi_if.master           spi,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int DW = $clog2(SCLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LOAD = DW'(SCLK_DIV - 1);

  generate
    if (NUM_CH != 2 && NUM_CH != 4) begin : g_bad_num_ch
      $error("dac_mixer_spi: NUM_CH must be 2 or 4");
    end
    if (SCLK_DIV < 1) begin : g_bad_sclk_div
      $error("dac_mixer_spi: SCLK_DIV must be >= 1");
    end
    if (SAMPLE_DIV < 32*SCLK_DIV + 4) begin : g_bad_sample_div
      $error("dac_mixer_spi: SAMPLE_DIV must be >= 32*SCLK_DIV+4");
    end
  endgenerate

  dac_state_t            state;
  logic [TW-1:0]         timer;
  logic                  tick;
  logic [FRAME_BITS-1:0] sreg;
  logic [DW-1:0]         div_cnt;
  logic [3:0]            bit_cnt;
  logic                  sclk_q;
  logic                  cs_n_q;
  logic [DAC_BITS-1:0]   mix_data;

  channel_mixer #(.NUM_CH(NUM_CH)) u_mixer (
    .ch_in   (ch_in),
    .ch_mute (ch_mute),
    .data    (mix_data)
  );

  assign tick = (timer == TW'(SAMPLE_DIV - 1));

`ifdef DAC_LDAC_EN
  logic ldac_q;
  assign spi.ldac_n = ldac_q;
`else
  assign spi.ldac_n = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      timer      <= '0;
      sreg       <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      frame_done <= 1'b0;
`ifdef DAC_LDAC_EN
      ldac_q     <= 1'b1;
`endif
    end else begin
      timer      <= tick ? '0 : timer + TW'(1);
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick && enable) begin
            state   <= ST_SHIFT;
            sreg    <= {DAC_CFG, mix_data};
            cs_n_q  <= 1'b0;
            sclk_q  <= 1'b0;
            div_cnt <= DIV_LOAD;
            bit_cnt <= 4'(FRAME_BITS - 1);
          end
        end
        ST_SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DW'(1);
          end else begin
            div_cnt <= DIV_LOAD;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else if (bit_cnt == 4'd0) begin
              state      <= ST_END;
              sclk_q     <= 1'b0;
              cs_n_q     <= 1'b1;
              frame_done <= 1'b1;
              sreg       <= '0;
            end else begin
              // falling sclk: next bit appears while sclk is low
              sclk_q  <= 1'b0;
              sreg    <= {sreg[FRAME_BITS-2:0], 1'b0};
              bit_cnt <= bit_cnt - 4'd1;
            end
          end
        end
        ST_END: begin
`ifdef DAC_LDAC_EN
          state  <= ST_LDAC;
          ldac_q <= 1'b0;
`else
          state  <= ST_IDLE;
`endif
        end
`ifdef DAC_LDAC_EN
        ST_LDAC: begin
          state  <= ST_IDLE;
          ldac_q <= 1'b1;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign spi.sclk = sclk_q;
  assign spi.cs_n = cs_n_q;
  assign spi.mosi = sreg[FRAME_BITS-1];
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_dac_mixer_spi.sv
// tb_dac_mixer_spi -- directed self-checking bench for dac_mixer_spi
// (NUM_CH=2, SCLK_DIV=2, SAMPLE_DIV=250). Honours DAC_LDAC_EN if defined.
module tb_dac_mixer_spi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [21:0] ch_in;
  logic [1:0]  ch_mute;
  logic        enable;
  logic        busy;
  logic        frame_done;

  dac_mixer_spi_if spi ();

  dac_mixer_spi #(.NUM_CH(2), .SCLK_DIV(2), .SAMPLE_DIV(250)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_in      (ch_in),
    .ch_mute    (ch_mute),
    .enable     (enable),
    .spi        (spi),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

`ifdef DAC_LDAC_EN
  localparam int   EXP_BUSY   = 66;
  localparam logic LDAC_IDLE  = 1'b1;
  localparam int   EXP_LPULSE = 1;
`else
  localparam int   EXP_BUSY   = 65;
  localparam logic LDAC_IDLE  = 1'b0;
  localparam int   EXP_LPULSE = 0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] fr_word;
  int fr_rises, fr_busy, fr_fd, fr_per_bad, fr_mosi_bad, fr_lpulse, fr_lpos_bad;
  bit fr_done;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fall(input int bound, output int n, output bit found);
    n = 0;
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      n++;
      if (spi.cs_n === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Called on the first sample with cs_n low; follows the frame until busy drops.
  task automatic run_frame(input int drop_at);
    logic prev_sclk, prev_mosi;
    int last_rise, cs_rise;
    prev_sclk = 1'b0;
    prev_mosi = spi.mosi;
    last_rise = -1;
    cs_rise = -1;
    fr_word = '0;
    fr_rises = 0; fr_busy = 0; fr_fd = 0; fr_per_bad = 0;
    fr_mosi_bad = 0; fr_lpulse = 0; fr_lpos_bad = 0;
    fr_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy === 1'b1) fr_busy++;
      if (frame_done === 1'b1) fr_fd++;
      if (spi.sclk === 1'b1 && prev_sclk === 1'b0) begin
        fr_rises++;
        fr_word = {fr_word[14:0], spi.mosi};
        if (last_rise >= 0 && i - last_rise != 4) fr_per_bad++;
        last_rise = i;
        if (fr_rises == drop_at) enable = 1'b0;
      end
      if (spi.sclk === 1'b1 && prev_sclk === 1'b1 && spi.mosi !== prev_mosi) fr_mosi_bad++;
      if (spi.cs_n === 1'b1 && cs_rise < 0) cs_rise = i;
      if (spi.ldac_n !== LDAC_IDLE) begin
        fr_lpulse++;
        if (i != cs_rise + 1) fr_lpos_bad++;
      end
      prev_sclk = spi.sclk;
      prev_mosi = spi.mosi;
      if (busy === 1'b0) begin
        fr_done = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] exp_word);
    chk({tag, "_done"},      32'(fr_done), 32'd1);
    chk({tag, "_word"},      32'(fr_word), 32'(exp_word));
    chk({tag, "_rises"},     fr_rises, 16);
    chk({tag, "_period"},    fr_per_bad, 0);
    chk({tag, "_busy"},      fr_busy, EXP_BUSY);
    chk({tag, "_fdone"},     fr_fd, 1);
    chk({tag, "_mosi_hi"},   fr_mosi_bad, 0);
    chk({tag, "_ldac"},      fr_lpulse, EXP_LPULSE);
    chk({tag, "_ldac_pos"},  fr_lpos_bad, 0);
  endtask

  initial begin
    int n, t0, rises, fd_seen;
    bit found;
    logic prev_sclk;

    ch_in = {11'h3FF, 11'h400};
    ch_mute = 2'b00;
    enable = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();

    chk("rst_cs_n",   32'(spi.cs_n),   32'd1);
    chk("rst_sclk",   32'(spi.sclk),   32'd0);
    chk("rst_mosi",   32'(spi.mosi),   32'd0);
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_fdone",  32'(frame_done), 32'd0);
    chk("rst_ldac_n", 32'(spi.ldac_n), 32'(LDAC_IDLE));

    rst_n = 1'b1;
    wait_fall(400, n, found);
    chk("f1_found", 32'(found), 32'd1);
    chk("f1_start", n, 250);
    t0 = cyc;
    ch_in = {11'h7FF, 11'h7FF};
    run_frame(0);
    check_frame("f1", 16'h37FF);

    wait_fall(400, n, found);
    chk("f2_found", 32'(found), 32'd1);
    chk("f2_spacing", cyc - t0, 250);
    t0 = cyc;
    ch_mute = 2'b10;
    run_frame(0);
    check_frame("f2", 16'h3FFE);

    wait_fall(400, n, found);
    chk("f3_spacing", cyc - t0, 250);
    ch_mute = 2'b00;
    ch_in = {11'h3FF, 11'h400};
    run_frame(0);
    check_frame("f3", 16'h37FF);

    wait_fall(400, n, found);
    chk("f4_found", 32'(found), 32'd1);
    run_frame(8);
    check_frame("f4_drop", 16'h37FF);

    wait_fall(760, n, found);
    chk("disabled_no_frame", 32'(found), 32'd0);

    enable = 1'b1;
    wait_fall(400, n, found);
    chk("f5_found", 32'(found), 32'd1);
    rises = 0;
    prev_sclk = spi.sclk;
    for (int i = 0; i < 100; i++) begin
      step();
      if (spi.sclk === 1'b1 && prev_sclk === 1'b0) rises++;
      prev_sclk = spi.sclk;
      if (rises == 7) break;
    end
    chk("f5_reached_bit7", rises, 7);
    rst_n = 1'b0;
    #1;
    chk("arst_cs_n",  32'(spi.cs_n),   32'd1);
    chk("arst_sclk",  32'(spi.sclk),   32'd0);
    chk("arst_busy",  32'(busy),       32'd0);
    fd_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (frame_done !== 1'b0) fd_seen++;
    end
    chk("arst_no_fdone", fd_seen, 0);
    rst_n = 1'b1;
    wait_fall(400, n, found);
    chk("post_rst_found", 32'(found), 32'd1);
    chk("post_rst_start", n, 250);
    run_frame(0);
    check_frame("f6", 16'h37FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
